board_keeper: RTL and testbench

- Holds the 15x15 gomoku board as two stone planes (black, white) and commits moves supplied by the input/AI side through a valid/ready handshake.
- For every accepted move it drives the win-checker interface (last row, last col, mover's plane) and samples the returned win_check one cycle later.
- From that result it tracks turn, winner and game-over state.
- It is the writer/driver side of the win-check interface.

---
 rtl/board_keeper.sv | 181 ++++++++++++++++++
 tb/tb_board_keeper.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_keeper.sv
// Gomoku board keeper: owns the black/white stone planes, commits handshaked
// moves, drives the external win checker and tracks turn/winner/game-over.
module board_keeper #(
  parameter int unsigned BOARD_N      = 15,
  parameter bit          FIRST_PLAYER = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         new_game,
  input  logic                         move_valid,
  input  logic [3:0]                   move_row,
  input  logic [3:0]                   move_col,
  output logic                         move_ready,
  output logic                         move_ack,
  output logic                         move_err,
  output logic [3:0]                   chk_row,
  output logic [3:0]                   chk_col,
  output logic [BOARD_N*BOARD_N-1:0]   chk_board,
  input  logic                         win_check,
  output logic [BOARD_N*BOARD_N-1:0]   black_board,
  output logic [BOARD_N*BOARD_N-1:0]   white_board,
  output logic                         turn,
  output logic                         game_over,
  output logic [1:0]                   winner,
  output logic [7:0]                   move_count
);

  localparam int unsigned CELLS = BOARD_N * BOARD_N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   black_q, black_d;
  logic [CELLS-1:0]   white_q, white_d;
  logic [3:0]         row_q, row_d;
  logic [3:0]         col_q, col_d;
  logic               mover_q, mover_d;
  logic               turn_q, turn_d;
  logic               over_q, over_d;
  logic [1:0]         winner_q, winner_d;
  logic [7:0]         count_q, count_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic               in_range;
  logic [7:0]         cell_idx;
  logic [CELLS-1:0]   cell_oh;
  logic               occupied;

  // Index is forced to 0 for off-board requests so the plane lookup never
  // selects beyond the plane; such requests are rejected regardless.
  always_comb begin
    in_range = (32'(move_row) < BOARD_N) && (32'(move_col) < BOARD_N);
    cell_idx = in_range ? 8'(32'(move_row) * BOARD_N + 32'(move_col)) : '0;
    cell_oh  = {{(CELLS-1){1'b0}}, 1'b1} << cell_idx;
    occupied = in_range && (black_q[cell_idx] || white_q[cell_idx]);
  end

  always_comb begin
    state_d  = state_q;
    black_d  = black_q;
    white_d  = white_q;
    row_d    = row_q;
    col_d    = col_q;
    mover_d  = mover_q;
    turn_d   = turn_q;
    over_d   = over_q;
    winner_d = winner_q;
    count_d  = count_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (move_valid) begin
          if (!in_range || occupied) begin
            err_d = 1'b1;
          end else begin
            if (turn_q) white_d = white_q | cell_oh;
            else        black_d = black_q | cell_oh;
            row_d   = move_row;
            col_d   = move_col;
            mover_d = turn_q;
            count_d = count_q + 8'd1;
            ack_d   = 1'b1;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (win_check) begin
          winner_d = mover_q ? 2'b10 : 2'b01;
          over_d   = 1'b1;
          state_d  = OVER;
        end else if (count_q == 8'(CELLS)) begin
          winner_d = 2'b11;
          over_d   = 1'b1;
          state_d  = OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = IDLE;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);

    if (new_game) begin
      state_d  = IDLE;
      black_d  = '0;
      white_d  = '0;
      row_d    = '0;
      col_d    = '0;
      mover_d  = 1'b0;
      turn_d   = FIRST_PLAYER;
      over_d   = 1'b0;
      winner_d = '0;
      count_d  = '0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      black_q  <= '0;
      white_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      mover_q  <= 1'b0;
      turn_q   <= FIRST_PLAYER;
      over_q   <= 1'b0;
      winner_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      black_q  <= black_d;
      white_q  <= white_d;
      row_q    <= row_d;
      col_q    <= col_d;
      mover_q  <= mover_d;
      turn_q   <= turn_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign chk_board   = mover_q ? white_q : black_q;
  assign black_board = black_q;
  assign white_board = white_q;
  assign chk_row     = row_q;
  assign chk_col     = col_q;
  assign turn        = turn_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign move_count  = count_q;
  assign move_ack    = ack_q;
  assign move_err    = err_q;
  assign move_ready  = ready_q;

endmodule

// File: tb/tb_board_keeper.sv
// Self-checking bench for board_keeper: vector table, hand-written corner
// sequences and random play against a 2-D board reference model.
module tb_board_keeper;

  logic         clk;
  logic         rst;
  logic         new_game;
  logic         move_valid;
  logic [3:0]   move_row;
  logic [3:0]   move_col;
  logic         move_ready;
  logic         move_ack;
  logic         move_err;
  logic [3:0]   chk_row;
  logic [3:0]   chk_col;
  logic [224:0] chk_board;
  logic         win_check;
  logic [224:0] black_board;
  logic [224:0] white_board;
  logic         turn;
  logic         game_over;
  logic [1:0]   winner;
  logic [7:0]   move_count;

  board_keeper #(.BOARD_N(15), .FIRST_PLAYER(1'b0)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .move_valid(move_valid), .move_row(move_row), .move_col(move_col),
    .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
    .chk_row(chk_row), .chk_col(chk_col), .chk_board(chk_board),
    .win_check(win_check),
    .black_board(black_board), .white_board(white_board),
    .turn(turn), .game_over(game_over), .winner(winner),
    .move_count(move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Win-checker environment: 0 = five-in-a-row rule, 1 = tied 0, 2 = tied 1
  int wc_mode = 0;

  // Reference model: 0 empty, 1 black, 2 white
  int brd [15][15];
  int m_turn, m_count, m_over, m_winner;
  int last_r, last_c;

  function automatic bit five_packed(logic [224:0] p, int r, int c);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int n = 1;
      int rr = r + dr[d];
      int cc = c + dc[d];
      while (rr >= 0 && rr < 15 && cc >= 0 && cc < 15 && p[rr*15+cc]) begin
        n++; rr += dr[d]; cc += dc[d];
      end
      rr = r - dr[d];
      cc = c - dc[d];
      while (rr >= 0 && rr < 15 && cc >= 0 && cc < 15 && p[rr*15+cc]) begin
        n++; rr -= dr[d]; cc -= dc[d];
      end
      if (n >= 5) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit five_at(int who, int r, int c);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int n = 0;
      for (int k = -4; k <= 4; k++) begin
        int rr = r + k * dr[d];
        int cc = c + k * dc[d];
        if (rr >= 0 && rr < 15 && cc >= 0 && cc < 15 && brd[rr][cc] == who) begin
          n++;
          if (n >= 5) return 1'b1;
        end else begin
          n = 0;
        end
      end
    end
    return 1'b0;
  endfunction

  always_comb begin
    if (wc_mode == 2)      win_check = 1'b1;
    else if (wc_mode == 1) win_check = 1'b0;
    else                   win_check = five_packed(chk_board, int'(chk_row), int'(chk_col));
  end

  function automatic logic [224:0] model_plane(int who);
    logic [224:0] p = '0;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        if (brd[r][c] == who) p[r*15+c] = 1'b1;
    return p;
  endfunction

  task automatic chk(input string name, input logic [224:0] act, input logic [224:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        brd[r][c] = 0;
    m_turn = 0; m_count = 0; m_over = 0; m_winner = 0;
  endtask

  task automatic model_commit(input int r, input int c);
    brd[r][c] = m_turn + 1;
    m_count++;
    last_r = r;
    last_c = c;
  endtask

  task automatic model_resolve();
    bit win;
    if (wc_mode == 2)      win = 1'b1;
    else if (wc_mode == 1) win = 1'b0;
    else                   win = five_at(m_turn + 1, last_r, last_c);
    if (win) begin
      m_over = 1; m_winner = m_turn + 1;
    end else if (m_count == 225) begin
      m_over = 1; m_winner = 3;
    end else begin
      m_turn = 1 - m_turn;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".turn"},   turn, 225'(m_turn));
    chk({tag, ".over"},   game_over, 225'(m_over));
    chk({tag, ".winner"}, winner, 225'(m_winner));
    chk({tag, ".count"},  move_count, 225'(m_count));
    chk({tag, ".ready"},  move_ready, 225'(m_over == 0));
    chk({tag, ".black"},  black_board, model_plane(1));
    chk({tag, ".white"},  white_board, model_plane(2));
  endtask

  // Called with the bench positioned 1 time unit after a rising edge.
  task automatic apply_move(input int r, input int c, output logic ack_o, output logic err_o);
    bit legal;
    legal = (m_over == 0) && r < 15 && c < 15 && brd[r][c] == 0;
    move_valid = 1'b1;
    move_row   = 4'(r);
    move_col   = 4'(c);
    @(posedge clk); #1;
    move_valid = 1'b0;
    ack_o = move_ack;
    err_o = move_err;
    chk("ack", move_ack, 225'(legal));
    chk("err", move_err, 225'((m_over == 0) && !legal));
    if (legal) begin
      model_commit(r, c);
      chk("chk_row", chk_row, 225'(r));
      chk("chk_col", chk_col, 225'(c));
      chk("ready_in_check", move_ready, '0);
      chk("chk_board", chk_board, model_plane(m_turn + 1));
      @(posedge clk); #1;
      model_resolve();
    end
    chk_state("move");
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_reset();
    chk_state("newgame");
  endtask

  typedef struct {
    int r;
    int c;
    bit ack;
    bit err;
    bit trn;
    int cnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic a, e;

    rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_row = '0; move_col = '0;
    model_reset();
    tbl[0] = '{r: 7,  c: 7,  ack: 1, err: 0, trn: 1, cnt: 1};
    tbl[1] = '{r: 7,  c: 7,  ack: 0, err: 1, trn: 1, cnt: 1};
    tbl[2] = '{r: 15, c: 3,  ack: 0, err: 1, trn: 1, cnt: 1};
    tbl[3] = '{r: 3,  c: 15, ack: 0, err: 1, trn: 1, cnt: 1};
    tbl[4] = '{r: 14, c: 14, ack: 1, err: 0, trn: 0, cnt: 2};
    tbl[5] = '{r: 0,  c: 0,  ack: 1, err: 0, trn: 1, cnt: 3};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_state("reset");
    chk("reset.ack", move_ack, '0);
    chk("reset.err", move_err, '0);
    chk("reset.chk_row", chk_row, '0);
    chk("reset.chk_col", chk_col, '0);

    // Basic accept / reject table
    for (int i = 0; i < 6; i++) begin
      apply_move(tbl[i].r, tbl[i].c, a, e);
      chk("tbl.ack", a, 225'(tbl[i].ack));
      chk("tbl.err", e, 225'(tbl[i].err));
      chk("tbl.turn", turn, 225'(tbl[i].trn));
      chk("tbl.count", move_count, 225'(tbl[i].cnt));
      if (i == 0) chk("tbl.bit112", black_board[112], 225'(1));
    end

    // Black wins with a horizontal five on row 0
    do_new_game();
    for (int k = 0; k < 5; k++) begin
      apply_move(0, k, a, e);
      if (k < 4) begin
        chk("win.not_over", game_over, '0);
        apply_move(1, k, a, e);
      end
    end
    chk("win.over", game_over, 225'(1));
    chk("win.winner", winner, 225'(1));
    apply_move(9, 9, a, e);
    chk("over.no_ack", a, '0);
    chk("over.no_err", e, '0);
    chk("over.ready", move_ready, '0);

    // move_valid held through CHECK is ignored until IDLE returns
    do_new_game();
    move_valid = 1'b1; move_row = 4'd2; move_col = 4'd2;
    @(posedge clk); #1;
    chk("hold.ack1", move_ack, 225'(1));
    model_commit(2, 2);
    move_row = 4'd3; move_col = 4'd3;
    @(posedge clk); #1;
    chk("hold.ack_check", move_ack, '0);
    chk("hold.err_check", move_err, '0);
    model_resolve();
    chk("hold.ready", move_ready, 225'(1));
    @(posedge clk); #1;
    move_valid = 1'b0;
    chk("hold.ack2", move_ack, 225'(1));
    chk("hold.white33", white_board[48], 225'(1));
    model_commit(3, 3);
    @(posedge clk); #1;
    model_resolve();
    chk_state("hold");

    // Fill the whole board without any win: draw
    wc_mode = 1;
    do_new_game();
    for (int i = 0; i < 225; i++) apply_move(i / 15, i % 15, a, e);
    chk("draw.winner", winner, 225'(3));
    chk("draw.over", game_over, 225'(1));
    chk("draw.count", move_count, 225'(225));
    apply_move(0, 0, a, e);
    chk("draw.count_held", move_count, 225'(225));

    // Asynchronous reset while a win is pending in CHECK
    wc_mode = 2;
    do_new_game();
    move_valid = 1'b1; move_row = 4'd5; move_col = 4'd5;
    @(posedge clk); #1;
    move_valid = 1'b0;
    chk("rst.ack", move_ack, 225'(1));
    rst = 1'b1;
    #2;
    chk("rst.async_black", black_board, '0);
    chk("rst.async_count", move_count, '0);
    chk("rst.async_winner", winner, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    wc_mode = 0;
    @(posedge clk); #1;
    chk_state("rst");

    // new_game and move_valid together: move dropped
    new_game = 1'b1; move_valid = 1'b1; move_row = 4'd4; move_col = 4'd4;
    @(posedge clk); #1;
    new_game = 1'b0; move_valid = 1'b0;
    chk("ng.ack", move_ack, '0);
    chk("ng.err", move_err, '0);
    chk_state("ng");
    @(posedge clk); #1;
    chk("ng.ack_late", move_ack, '0);

    // Random play against the reference model
    do_new_game();
    for (int i = 0; i < 400; i++) begin
      if (m_over != 0) do_new_game();
      apply_move(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), a, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
